mod_mul_serial: RTL and testbench
=================================

Name: mod_mul_serial

Overview:
- Bit-serial interleaved modular multiplier: computes (a*b) mod n, one multiplier bit per clock, MSB first.
- It is the responder side of the single-cycle start-pulse / single-cycle finished-pulse handshake that the ECC point-arithmetic controllers (point double/add) use to issue modular products.
- It replaces the modular-product responder on the `i_start`/`o_finished` interface, and adds operand latching and a busy flag.

Parameters:
- MAX_BITS, 256, operand/modulus width in bits.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request pulse; sampled only when idle.
- i_n  input  MAX_BITS  modulus; requires n >= 2.
- i_a  input  MAX_BITS  multiplicand; requires a < 2n.
- i_b  input  MAX_BITS  multiplier; any value.
- o_result  output  MAX_BITS  (a*b) mod n; always in [0, n-1].
- o_finished  output  1  one-cycle completion pulse.
- o_busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (i_rst_n=0, asynchronous, independent of clock):
  - state=IDLE; counter and accumulator cleared.
  - o_result=0, o_finished=0, o_busy=0.
  - Reset asserted mid-operation aborts it: no o_finished pulse follows, o_result stays 0.
- States: IDLE, CALC. No other states.
- IDLE:
  - o_busy=0.
  - On an edge with i_start=1 (edge E0): latch n, b, and a' = (a>=n) ? a-n : a.
  - Also at E0: clear acc, set bit counter to MAX_BITS-1, go to CALC.
  - i_n/i_a/i_b may change freely after E0.
- CALC (o_busy=1), each edge processes bit i = counter:
  - t = 2*acc; if t>=n then t=t-n.
  - if b[i]=1 then t=t+a'; if t>=n then t=t-n.
  - acc=t; counter decrements.
  - Internal datapath width is MAX_BITS+2 bits, so no overflow when n is near 2^MAX_BITS.
  - Invariant: acc < n after every edge.
- Completion:
  - The edge processing bit 0 is edge E_MAX_BITS.
  - At that edge: o_result <= final acc, o_finished <= 1, state <= IDLE.
  - Latency is exactly MAX_BITS cycles from the start-sampling edge to o_finished high.
- o_finished:
  - High for exactly one cycle, then 0.
  - Never asserted except at completion.
- o_result:
  - Updates only at completion.
  - Holds its value until the next completion or reset.
- i_start while busy: ignored; no queuing, no effect on the operation in flight.
- Back-to-back: i_start=1 in the cycle o_finished is high is accepted (block is already IDLE).
  - Next result arrives MAX_BITS cycles later; o_result holds the previous result meanwhile.
- Edge operand values:
  - b=0 or a'=0 gives result 0.
  - Operands equal to n-1 must give the correct value (1 for (n-1)^2).
- Requests violating a<2n or n>=2 produce an unspecified o_result.
  - Handshake timing is still exact for such requests.

Test Plan:
- MAX_BITS=8, n=251, a=200, b=100, one-cycle i_start -> o_finished pulses exactly 8 cycles after the start edge; o_result=171; o_busy high for those 8 cycles.
- n=251, a=250, b=250 -> o_result=1. Then a=0, b=255 -> 0. Then a=37, b=0 -> 0.
- n=251, a=252 (>=n), b=3 -> a reduced to 1, o_result=3. Then n=255, a=254, b=254 -> o_result=1 (checks wide datapath near 2^MAX_BITS).
- Start a=200, b=100 (n=251); pulse i_start with a=5, b=5 during cycle 4 of CALC -> ignored; o_result=171 at cycle 8; no second o_finished.
- Back-to-back: second i_start coincident with first o_finished, a=3, b=7, n=251 -> first result 171, second o_finished 8 cycles later with o_result=21; o_result holds 171 in between.
- Assert i_rst_n=0 mid-CALC, asynchronously between edges -> o_busy, o_finished, o_result go to 0 immediately with no pending pulse. After release, a new request n=251, a=2, b=3 -> o_result=6 after 8 cycles.
- Random regression at MAX_BITS=256 with the P-256 prime, a,b < n -> o_result matches reference-model (a*b) mod n; latency 256 cycles every time.

Source files
------------

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial interleaved modular multiplier, result = (a*b) mod n, MSB first
//   i_clk, i_rst_n (async, active low)
//   i_start            : request pulse, sampled only while idle
//   i_n, i_a, i_b      : modulus (n >= 2), multiplicand (a < 2n), multiplier
//   o_result           : last completed product, held until next completion
//   o_finished         : one-cycle completion pulse
//   o_busy             : high while a product is in progress
module mod_mul_serial #(
    parameter int MAX_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [MAX_BITS-1:0] i_n,
    input  logic [MAX_BITS-1:0] i_a,
    input  logic [MAX_BITS-1:0] i_b,
    output logic [MAX_BITS-1:0] o_result,
    output logic                o_finished,
    output logic                o_busy
);
    localparam int W  = MAX_BITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic {IDLE, CALC} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    n_q, n_d, a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic            fin_q, fin_d;
    // two guard bits keep 2*acc and the post-add sum exact when n is close to 2^W
    logic [W+1:0]    n_ext, dbl, t1, sum;
    always_comb begin
        n_ext   = {2'b00, n_q};
        dbl     = {1'b0, acc_q, 1'b0};
        t1      = dbl - ((dbl >= n_ext) ? n_ext : '0);
        sum     = t1 + (b_q[cnt_q] ? {2'b00, a_q} : '0);
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        fin_d   = 1'b0;
        if (state_q == IDLE) begin
            if (i_start) begin
                n_d     = i_n;
                b_d     = i_b;
                // a < 2n, so one conditional subtraction brings a into [0, n-1]
                a_d     = i_a - ((i_a >= i_n) ? i_n : '0);
                acc_d   = '0;
                cnt_d   = CW'(W - 1);
                state_d = CALC;
            end
        end else begin
            // sum < 2n, so the reduced value fits in W bits
            acc_d = sum[W-1:0] - ((sum >= n_ext) ? n_q : '0);
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                res_d   = acc_d;
                fin_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            fin_q   <= fin_d;
        end
    end
    assign o_result   = res_q;
    assign o_finished = fin_q;
    assign o_busy     = (state_q == CALC);
endmodule

// File: tb/tb_mod_mul_serial.sv
// tb_mod_mul_serial: randomized and directed check of mod_mul_serial against a behavioural model
module tb_mod_mul_serial;
    localparam logic [255:0] P256 = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    logic clk = 1'b0, rst_n = 1'b0;
    logic s8 = 1'b0;
    logic [7:0] n8 = '0, a8 = '0, b8 = '0, r8;
    logic f8, bz8;
    logic sb = 1'b0;
    logic [255:0] nb = '0, ab = '0, bb = '0, rb;
    logic fb, bzb;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mod_mul_serial #(.MAX_BITS(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_n(n8), .i_a(a8), .i_b(b8),
        .o_result(r8), .o_finished(f8), .o_busy(bz8)
    );
    mod_mul_serial #(.MAX_BITS(256)) dutb (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(sb), .i_n(nb), .i_a(ab), .i_b(bb),
        .o_result(rb), .o_finished(fb), .o_busy(bzb)
    );

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return 8'(p % 16'(n));
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n);
        logic [511:0] p;
        p = 512'(a) * 512'(b);
        return 256'(p % 512'(n));
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a request accepted while idle yields its product exactly W edges later.
    logic m8_busy = 1'b0, m8_fin = 1'b0;
    logic [7:0] m8_res = '0, m8_pend = '0;
    int m8_left = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_busy <= 1'b0; m8_fin <= 1'b0; m8_res <= '0; m8_left <= 0;
        end else begin
            m8_fin <= 1'b0;
            if (m8_busy) begin
                if (m8_left == 1) begin
                    m8_busy <= 1'b0; m8_fin <= 1'b1; m8_res <= m8_pend;
                end
                m8_left <= m8_left - 1;
            end else if (s8) begin
                m8_busy <= 1'b1; m8_left <= 8; m8_pend <= ref8(a8, b8, n8);
            end
        end
    end

    logic mb_busy = 1'b0, mb_fin = 1'b0;
    logic [255:0] mb_res = '0, mb_pend = '0;
    int mb_left = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_busy <= 1'b0; mb_fin <= 1'b0; mb_res <= '0; mb_left <= 0;
        end else begin
            mb_fin <= 1'b0;
            if (mb_busy) begin
                if (mb_left == 1) begin
                    mb_busy <= 1'b0; mb_fin <= 1'b1; mb_res <= mb_pend;
                end
                mb_left <= mb_left - 1;
            end else if (sb) begin
                mb_busy <= 1'b1; mb_left <= 256; mb_pend <= ref256(ab, bb, nb);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy8", 256'(bz8), 256'(m8_busy));
        chk("fin8", 256'(f8), 256'(m8_fin));
        chk("res8", 256'(r8), 256'(m8_res));
        chk("busy256", 256'(bzb), 256'(mb_busy));
        chk("fin256", 256'(fb), 256'(mb_fin));
        chk("res256", rb, mb_res);
    end

    task automatic start8(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b);
        n8 = n; a8 = a; b8 = b; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    task automatic wait8(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!f8 && c < 40);
    endtask

    task automatic start256(input logic [255:0] n, input logic [255:0] a, input logic [255:0] b);
        nb = n; ab = a; bb = b; sb = 1'b1;
        @(negedge clk);
        sb = 1'b0;
    endtask

    task automatic wait256(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!fb && c < 600);
    endtask

    task automatic count_fin8(output int nf);
        nf = 0;
        repeat (12) begin
            @(negedge clk);
            if (f8) nf++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c, nf;
        logic [7:0] tn[5], ta[5], tb[5], te[5];
        logic [255:0] ra, rbv;
        tn = '{8'd251, 8'd251, 8'd251, 8'd251, 8'd255};
        ta = '{8'd250, 8'd0,   8'd37,  8'd252, 8'd254};
        tb = '{8'd250, 8'd255, 8'd0,   8'd3,   8'd254};
        te = '{8'd1,   8'd0,   8'd0,   8'd3,   8'd1};
        #1;
        chk("rst_res8", 256'(r8), 0);
        chk("rst_fin8", 256'(f8), 0);
        chk("rst_busy8", 256'(bz8), 0);
        chk("rst_res256", rb, 0);
        chk("rst_busy256", 256'(bzb), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start8(8'd251, 8'd200, 8'd100);
        chk("busy_after_start", 256'(bz8), 1);
        wait8(c);
        chk("lat_basic", 256'(c), 8);
        chk("res_basic", 256'(r8), 171);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            start8(tn[i], ta[i], tb[i]);
            wait8(c);
            chk("lat_edge", 256'(c), 8);
            chk("res_edge", 256'(r8), 256'(te[i]));
            @(negedge clk);
        end
        start8(8'd251, 8'd200, 8'd100);
        repeat (3) @(negedge clk);
        a8 = 8'd5; b8 = 8'd5; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        wait8(c);
        chk("lat_ignored", 256'(c), 4);
        chk("res_ignored", 256'(r8), 171);
        count_fin8(nf);
        chk("no_extra_fin", 256'(nf), 0);
        start8(8'd251, 8'd200, 8'd100);
        wait8(c);
        chk("b2b_res1", 256'(r8), 171);
        start8(8'd251, 8'd3, 8'd7);
        chk("b2b_hold", 256'(r8), 171);
        wait8(c);
        chk("b2b_lat", 256'(c), 8);
        chk("b2b_res2", 256'(r8), 21);
        @(negedge clk);
        start8(8'd251, 8'd200, 8'd100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 256'(bz8), 0);
        chk("arst_fin", 256'(f8), 0);
        chk("arst_res", 256'(r8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_fin8(nf);
        chk("arst_no_fin", 256'(nf), 0);
        chk("arst_res_held", 256'(r8), 0);
        start8(8'd251, 8'd2, 8'd3);
        wait8(c);
        chk("arst_lat", 256'(c), 8);
        chk("arst_res_new", 256'(r8), 6);
        @(negedge clk);
        start256(P256, P256 - 1, P256 - 1);
        wait256(c);
        chk("p256_lat", 256'(c), 256);
        chk("p256_nm1_sq", rb, 1);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            ra = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rbv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (rbv >= P256) rbv = rbv - P256;
            if (k % 2 == 0 && ra >= P256) ra = ra - P256;
            if (k == 3) rbv = '0;
            start256(P256, ra, rbv);
            wait256(c);
            chk("rand_lat", 256'(c), 256);
            chk("rand_res", rb, ref256(ra, rbv, P256));
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
